// File: rtl/serial_subtractor_if.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor_if
// Description : Input/output valid-ready bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic             underflow;
  logic             overflow;

  modport master (
    output in_valid, sum, a, out_ready,
    input  in_ready, out_valid, b, underflow, overflow
  );

  modport slave (
    input  in_valid, sum, a, out_ready,
    output in_ready, out_valid, b, underflow, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor
// Description : Bit-serial b = sum - a, LSB first, with range flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 2);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]     r_s_sh;
  logic [WIDTH:0]     r_a_sh;
  logic [WIDTH:0]     r_r_sh;
  logic               r_borrow;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_s0;
  logic w_a0;
  logic w_d;
  logic w_borrow_next;
  logic w_done;

  assign w_s0          = r_s_sh[0];
  assign w_a0          = r_a_sh[0];
  assign w_d           = w_s0 ^ w_a0 ^ r_borrow;
  assign w_borrow_next = (~w_s0 & w_a0) | (~(w_s0 ^ w_a0) & r_borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)    w_state_next = S_SHIFT;
      S_SHIFT: if (r_cnt == c_last) w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_sh   <= '0;
      r_a_sh   <= '0;
      r_r_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_s_sh   <= bus.sum;
            r_a_sh   <= {1'b0, bus.a};
            r_r_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          // Result bits enter at the top so the LSB ends up at bit 0.
          r_r_sh   <= {w_d, r_r_sh[WIDTH:1]};
          r_s_sh   <= {1'b0, r_s_sh[WIDTH:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH:1]};
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_done        = (r_state == S_DONE);
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = w_done;
  assign bus.b         = w_done ? r_r_sh[WIDTH-1:0] : '0;
  assign bus.underflow = w_done & r_borrow;
  // A set top bit with no final borrow means the true difference needs WIDTH+1 bits.
  assign bus.overflow  = w_done & r_r_sh[WIDTH] & ~r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [4:0] s, input logic [3:0] av);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bus.sum      = s;
    bus.a        = av;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sum       = 5'd31;
    bus.a         = 4'd0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.b !== 4'd0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: b=%h uf=%b of=%b required 0 0 0", bus.b, bus.underflow, bus.overflow);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    do_accept(5'd9, 4'd3);
    wait_done(lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 5", lat);
    end
    checks++;
    if (bus.b !== 4'd6 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: b=%h uf=%b of=%b required 6 0 0", bus.b, bus.underflow, bus.overflow);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_after: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_underflow();
    int lat;
    bus.out_ready = 1'b1;
    do_accept(5'd2, 4'd5);
    wait_done(lat);
    checks++;
    if (lat != 5 || bus.b !== 4'hD || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_2_5: lat=%0d b=%h uf=%b of=%b required 5 d 1 0", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
    do_accept(5'd0, 4'd15);
    wait_done(lat);
    checks++;
    if (lat != 5 || bus.b !== 4'h1 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_0_15: lat=%0d b=%h uf=%b of=%b required 5 1 1 0", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    bus.out_ready = 1'b1;
    do_accept(5'd30, 4'd2);
    wait_done(lat);
    checks++;
    if (lat != 5 || bus.b !== 4'hC || bus.underflow !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL of_30_2: lat=%0d b=%h uf=%b of=%b required 5 c 0 1", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
    do_accept(5'd16, 4'd0);
    wait_done(lat);
    checks++;
    if (lat != 5 || bus.b !== 4'h0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL of_16_0: lat=%0d b=%h uf=%b of=%b required 5 0 0 1", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
  endtask

  task automatic test_round_trip();
    int         lat;
    logic [3:0] av;
    logic [3:0] bv;
    logic [4:0] sv;
    logic       stall;
    for (int i = 0; i < 256; i++) begin
      av    = 4'(i >> 4);
      bv    = 4'(i);
      sv    = {1'b0, av} + {1'b0, bv};
      stall = (i % 37) == 0;
      bus.out_ready = ~stall;
      do_accept(sv, av);
      wait_done(lat);
      checks++;
      if (lat != 5 || bus.b !== bv || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL rt a=%h b=%h: lat=%0d b=%h uf=%b of=%b required 5 %h 0 0",
                 av, bv, lat, bus.b, bus.underflow, bus.overflow, bv);
      end
      if (stall) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.b !== bv ||
              bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rt_stall a=%h b=%h: ov=%b ir=%b b=%h uf=%b of=%b required 1 0 %h 0 0",
                     av, bv, bus.out_valid, bus.in_ready, bus.b, bus.underflow, bus.overflow, bv);
          end
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.out_ready = 1'b1;
    do_accept(5'd9, 4'd3);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.b !== 4'd0 ||
        bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ir=%b ov=%b b=%h uf=%b of=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.b, bus.underflow, bus.overflow);
    end
    repeat (2) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_hold: ov=%b ir=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    do_accept(5'd20, 4'd7);
    wait_done(lat);
    checks++;
    if (lat != 5 || bus.b !== 4'd13 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_next: lat=%0d b=%h uf=%b of=%b required 5 d 0 0", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    bus.out_ready = 1'b1;
    do_accept(5'd9, 4'd3);
    bus.sum = 5'd31;
    bus.a   = 4'd0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      bus.in_valid = ~bus.in_valid;
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_ready cycle %0d: in_ready=%b required 0", k, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (lat != 5 || bus.b !== 4'd6 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d b=%h uf=%b of=%b required 5 6 0 0", lat, bus.b, bus.underflow, bus.overflow);
    end
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_after: ir=%b ov=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    bus.in_valid  = 1'b0;
    bus.sum       = '0;
    bus.a         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_round_trip();
    test_reset_mid();
    test_ignore_in_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial inverse of the `adder` block. Given a sum (WIDTH+1 bits) and one operand `a`, it recovers the other operand `b = sum - a`.
- Processes one bit per clock, LSB first, with a valid/ready handshake on both input and output.
- Used as the on-board round-trip checker behind `adder`, and as the small sequential datapath example in the design.
- Flags results that do not fit in WIDTH bits.

Parameters:
- WIDTH, 4, operand width. `sum` is WIDTH+1 bits and `b` is WIDTH bits. Legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  `sum` and `a` are valid
- in_ready  output  1  block can accept a new operation
- sum  input  WIDTH+1  minuend (an `adder` output)
- a  input  WIDTH  subtrahend (zero-extended internally to WIDTH+1 bits)
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- b  output  WIDTH  low WIDTH bits of `sum - a`
- underflow  output  1  `sum < a`; `b` holds the two's-complement wrap
- overflow  output  1  `sum - a > 2^WIDTH - 1`; `b` is truncated

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - Shift registers, borrow and bit counter cleared.
  - out_valid = 0, b = 0, underflow = 0, overflow = 0.
  - in_ready = 1 (decoded from IDLE).
  - Inputs are ignored while rst_n is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Acceptance happens on an edge where in_valid && in_ready.
  - At acceptance: latch `sum` into s_sh, `{1'b0, a}` into a_sh; clear borrow, counter and r_sh; go to SHIFT.
  - Inputs are sampled only at acceptance. Later changes have no effect.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each edge, with s0 = s_sh[0], a0 = a_sh[0]:
    - d = s0 ^ a0 ^ borrow
    - borrow_next = (~s0 & a0) | (~(s0 ^ a0) & borrow)
    - r_sh = {d, r_sh[WIDTH:1]}
    - s_sh and a_sh shift right by one
    - counter increments
  - After WIDTH+1 shift edges, go to DONE.
  - in_valid is ignored in this state.
- DONE:
  - out_valid = 1, in_ready = 0.
  - b = r_sh[WIDTH-1:0]
  - underflow = borrow
  - overflow = r_sh[WIDTH] & ~borrow
  - Outputs hold stable until out_valid && out_ready on an edge, then go to IDLE.
  - out_valid drops the cycle after the handshake.
- Latency: out_valid rises exactly WIDTH+1 edges after the acceptance edge (5 cycles at WIDTH=4).
- Throughput: one operation per WIDTH+3 cycles minimum. No accept in the same cycle as the output handshake.
- Flag rules:
  - underflow and overflow are never both 1.
  - Both are 0 if and only if b == sum - a exactly.
- Width and arithmetic:
  - Pure modulo-2^(WIDTH+1) subtraction.
  - The counter is wide enough to hold WIDTH+1 ($clog2(WIDTH+2) bits).
- Reset mid-operation (SHIFT or DONE):
  - The operation is aborted with no output.
  - After release: IDLE with in_ready = 1, and the next transaction is correct.
- out_ready held high before DONE: no effect until out_valid = 1.

Test Plan (WIDTH=4):
1. sum=9, a=3, out_ready=1 → out_valid rises 5 edges after accept; b=6, underflow=0, overflow=0; out_valid low the next cycle; in_ready high.
2. sum=2, a=5 → b=4'hD, underflow=1, overflow=0. Also sum=0, a=15 → b=4'h1, underflow=1.
3. sum=30, a=2 → b=4'hC, overflow=1, underflow=0. Also sum=16, a=0 → b=0, overflow=1.
4. Round trip: for all 256 values of {a,b}, feed `adder` output as `sum` with the same `a` → recovered b equals the driven b, both flags 0. Interleave out_ready low for 3 cycles → b, flags and out_valid stable; in_ready=0 throughout.
5. Accept sum=9, a=3. Pull rst_n low 2 cycles into SHIFT → outputs zero immediately, in_ready=1. After release, run sum=20, a=7 → b=13, flags 0.
6. During SHIFT, toggle in_valid with sum=31, a=0 → ignored; in_ready stays 0; the original result is unchanged.
